// File: rtl/envolve_scheduler_pkg.sv
// Shared definitions for the evolution scheduler: address width, FSM encoding
// and the tick-period helper.
package envolve_scheduler_pkg;

    localparam int unsigned ADDR_WIDTH = 8;

    typedef enum logic [1:0] {
        StPause = 2'd0,
        StRun   = 2'd1,
        StClear = 2'd2
    } sched_state_e;

    // Last counter value of a tick period at the given speed.
    function automatic logic [31:0] tick_limit(input int unsigned base, input logic [2:0] shift);
        return (base >> shift) - 32'd1;
    endfunction

endpackage

// File: rtl/clear_sweeper.sv
// Row-major address walker: on start it issues (0,0) in the same cycle, then one
// address per cycle until the last cell of the map.
module clear_sweeper
    import envolve_scheduler_pkg::*;
#(
    parameter int unsigned MAP_WIDTH  = 8,
    parameter int unsigned MAP_HEIGHT = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  valid_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] row_o,
    output logic [ADDR_WIDTH-1:0] col_o
);

    localparam logic [ADDR_WIDTH-1:0] LastRow = ADDR_WIDTH'(MAP_HEIGHT - 1);
    localparam logic [ADDR_WIDTH-1:0] LastCol = ADDR_WIDTH'(MAP_WIDTH - 1);

    logic                  active_q, active_d;
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;

    // A start restarts the walk at (0,0) even while a sweep is in progress.
    always_comb begin
        valid_o  = start_i | active_q;
        row_o    = start_i ? '0 : row_q;
        col_o    = start_i ? '0 : col_q;
        done_o   = valid_o && (row_o == LastRow) && (col_o == LastCol);
        active_d = valid_o && !done_o;
        row_d    = row_q;
        col_d    = col_q;
        if (done_o) begin
            row_d = '0;
            col_d = '0;
        end else if (valid_o) begin
            if (col_o == LastCol) begin
                col_d = '0;
                row_d = row_o + ADDR_WIDTH'(1);
            end else begin
                col_d = col_o + ADDR_WIDTH'(1);
                row_d = row_o;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            active_q <= active_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

endmodule

// File: rtl/envolve_scheduler.sv
// Run/pause/step sequencer for the evolve datapath: generates the generation tick
// and arbitrates the map write port between editor writes and the clear sweep.
module envolve_scheduler
    import envolve_scheduler_pkg::*;
#(
    parameter int unsigned MAP_WIDTH   = 8,
    parameter int unsigned MAP_HEIGHT  = 8,
    parameter int unsigned BASE_PERIOD = 25_000_000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_toggle_i,
    input  logic                  step_req_i,
    input  logic                  clear_req_i,
    input  logic [2:0]            speed_i,
    input  logic                  edit_we_i,
    input  logic [ADDR_WIDTH-1:0] edit_row_i,
    input  logic [ADDR_WIDTH-1:0] edit_col_i,
    input  logic                  edit_data_i,
    output logic                  envo_tick_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_row_o,
    output logic [ADDR_WIDTH-1:0] wr_col_o,
    output logic                  wr_data_o,
    output logic                  running_o,
    output logic                  busy_o
);

    localparam int unsigned CntWidth = $clog2(BASE_PERIOD);

    sched_state_e          state_q, state_d;
    sched_state_e          resume_q, resume_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic                  tick_q, tick_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [ADDR_WIDTH-1:0] wr_col_q, wr_col_d;
    logic                  wr_data_q, wr_data_d;
    logic                  running_q, running_d;
    logic                  busy_q, busy_d;

    logic                  sweep_valid, sweep_done;
    logic [ADDR_WIDTH-1:0] sweep_row, sweep_col;
    logic                  tick_due, edit_ok, idle_cycle;

    clear_sweeper #(
        .MAP_WIDTH (MAP_WIDTH),
        .MAP_HEIGHT(MAP_HEIGHT)
    ) u_sweeper (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(clear_req_i),
        .valid_o(sweep_valid),
        .done_o (sweep_done),
        .row_o  (sweep_row),
        .col_o  (sweep_col)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StPause;
            resume_q  <= StPause;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_data_q <= 1'b0;
            running_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_data_q <= wr_data_d;
            running_q <= running_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        if (clear_req_i) begin
            state_d = StClear;
            if (state_q != StClear) begin
                resume_d = state_q;
            end
        end else begin
            unique case (state_q)
                StPause: if (run_toggle_i) state_d = StRun;
                StRun:   if (run_toggle_i) state_d = StPause;
                StClear: if (sweep_done || !sweep_valid) state_d = resume_q;
                default: state_d = StPause;
            endcase
        end
    end

    // Period counter and tick/write arbitration; clear and toggle cycles never tick.
    always_comb begin
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        tick_due   = 1'b0;
        tick_d     = 1'b0;
        idle_cycle = !clear_req_i && !run_toggle_i && (state_q != StClear);
        edit_ok    = edit_we_i && !sweep_valid;
        if (idle_cycle && state_q == StRun) begin
            if (32'(cnt_q) >= tick_limit(BASE_PERIOD, speed_i)) begin
                tick_due = 1'b1;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CntWidth'(1);
            end
        end else if (idle_cycle && state_q == StPause) begin
            tick_due = step_req_i;
        end
        if (!clear_req_i && run_toggle_i && state_q == StPause) begin
            cnt_d = '0;
        end
        if (!idle_cycle) begin
            pending_d = 1'b0;
        end else if (tick_due || pending_q) begin
            tick_d    = !edit_ok;
            pending_d = edit_ok;
        end
    end

    always_comb begin
        wr_en_d   = sweep_valid | edit_ok;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_data_d = wr_data_q;
        if (sweep_valid) begin
            wr_row_d  = sweep_row;
            wr_col_d  = sweep_col;
            wr_data_d = 1'b0;
        end else if (edit_ok) begin
            wr_row_d  = edit_row_i;
            wr_col_d  = edit_col_i;
            wr_data_d = edit_data_i;
        end
        busy_d    = sweep_valid;
        running_d = (state_d == StRun) || (state_d == StClear && resume_d == StRun);
    end

    assign envo_tick_o = tick_q;
    assign wr_en_o     = wr_en_q;
    assign wr_row_o    = wr_row_q;
    assign wr_col_o    = wr_col_q;
    assign wr_data_o   = wr_data_q;
    assign running_o   = running_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_envolve_scheduler.sv
// Directed bench for envolve_scheduler: expected ticks and writes are queued with
// their due cycle and matched against every tick/write the DUT emits.
module tb_envolve_scheduler;
    import envolve_scheduler_pkg::*;

    localparam int unsigned MW = 4;
    localparam int unsigned MH = 3;
    localparam int unsigned BP = 256;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  run_toggle = 1'b0;
    logic                  step_req = 1'b0;
    logic                  clear_req = 1'b0;
    logic [2:0]            speed = 3'd0;
    logic                  edit_we = 1'b0;
    logic [ADDR_WIDTH-1:0] edit_row = '0;
    logic [ADDR_WIDTH-1:0] edit_col = '0;
    logic                  edit_data = 1'b0;
    logic                  envo_tick, wr_en, wr_data, running, busy;
    logic [ADDR_WIDTH-1:0] wr_row, wr_col;

    typedef struct {
        bit is_tick;
        int cycle;
        int row;
        int col;
        int data;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;

    envolve_scheduler #(
        .MAP_WIDTH  (MW),
        .MAP_HEIGHT (MH),
        .BASE_PERIOD(BP)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .run_toggle_i(run_toggle),
        .step_req_i  (step_req),
        .clear_req_i (clear_req),
        .speed_i     (speed),
        .edit_we_i   (edit_we),
        .edit_row_i  (edit_row),
        .edit_col_i  (edit_col),
        .edit_data_i (edit_data),
        .envo_tick_o (envo_tick),
        .wr_en_o     (wr_en),
        .wr_row_o    (wr_row),
        .wr_col_o    (wr_col),
        .wr_data_o   (wr_data),
        .running_o   (running),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next();
    endtask

    task automatic push_tick(input int c);
        sb.push_back('{1'b1, c, 0, 0, 0});
    endtask

    task automatic push_wr(input int c, input int row, input int col, input int data);
        sb.push_back('{1'b0, c, row, col, data});
    endtask

    // Every tick or write the DUT emits must match the oldest queued expectation.
    always @(negedge clk) begin
        if (envo_tick === 1'b1 || wr_en === 1'b1) begin
            check("tick_wr_overlap", 32'(envo_tick & wr_en), 0);
            check("sb_has_entry", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("ev_is_tick", 32'(envo_tick), 32'(mon_e.is_tick));
                check("ev_cycle", cyc, mon_e.cycle);
                if (!mon_e.is_tick) begin
                    check("wr_row", 32'(wr_row), mon_e.row);
                    check("wr_col", 32'(wr_col), mon_e.col);
                    check("wr_data", 32'(wr_data), mon_e.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, c, r, u, p, s;
        repeat (3) next();
        check("rst_tick", 32'(envo_tick), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_row", 32'(wr_row), 0);
        check("rst_wr_col", 32'(wr_col), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_running", 32'(running), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        next();

        // Run ticks and speed changes
        t = cyc;
        push_tick(t + 257);
        push_tick(t + 513);
        run_toggle = 1'b1;
        next();
        run_toggle = 1'b0;
        check("run_rise", 32'(running), 1);
        wait_until(t + 513);
        speed = 3'd3;
        push_tick(t + 545);
        push_tick(t + 577);
        wait_until(t + 577);
        speed = 3'd0;
        push_tick(t + 618);  // cnt=40 above the speed-3 limit: fires at once
        push_tick(t + 650);
        wait_until(t + 617);
        speed = 3'd3;
        wait_until(t + 650);
        speed = 3'd0;
        push_tick(t + 906);
        wait_until(t + 910);
        run_toggle = 1'b1;
        next();
        run_toggle = 1'b0;
        check("pause_fall", 32'(running), 0);

        // Single step in PAUSE, ignored in RUN
        wait_until(t + 920);
        c = cyc;
        push_tick(c + 1);
        step_req = 1'b1;
        next();
        step_req = 1'b0;
        wait_until(c + 5);
        run_toggle = 1'b1;
        next();
        run_toggle = 1'b0;
        check("run_again", 32'(running), 1);
        wait_until(c + 10);
        step_req = 1'b1;
        next();
        step_req = 1'b0;

        // Clear in RUN with an editor write mid-sweep
        wait_until(c + 20);
        r = cyc;
        for (int i = 0; i < 12; i++) push_wr(r + 1 + i, i / 4, i % 4, 0);
        clear_req = 1'b1;
        next();
        clear_req = 1'b0;
        check("clr_busy_start", 32'(busy), 1);
        check("clr_running_held", 32'(running), 1);
        wait_until(r + 5);
        edit_we = 1'b1;
        edit_row = 8'd1;
        edit_col = 8'd1;
        edit_data = 1'b1;
        next();
        edit_we = 1'b0;
        wait_until(r + 12);
        check("clr_busy_last", 32'(busy), 1);
        next();
        check("clr_busy_done", 32'(busy), 0);
        check("clr_resume_run", 32'(running), 1);
        wait_until(r + 20);
        run_toggle = 1'b1;
        next();
        run_toggle = 1'b0;
        check("pause_after_clr", 32'(running), 0);

        // Editor write colliding with a due tick
        wait_until(r + 25);
        u = cyc;
        push_tick(u + 257);
        run_toggle = 1'b1;
        next();
        run_toggle = 1'b0;
        wait_until(u + 512);
        push_wr(u + 513, 2, 1, 1);
        push_tick(u + 514);
        push_tick(u + 769);
        edit_we = 1'b1;
        edit_row = 8'd2;
        edit_col = 8'd1;
        edit_data = 1'b1;
        next();
        edit_we = 1'b0;
        wait_until(u + 775);
        run_toggle = 1'b1;
        next();
        run_toggle = 1'b0;
        check("pause_after_conflict", 32'(running), 0);

        // Clear + toggle together in PAUSE, then a restart at write 5
        wait_until(u + 780);
        p = cyc;
        for (int i = 0; i < 5; i++) push_wr(p + 1 + i, i / 4, i % 4, 0);
        for (int i = 0; i < 12; i++) push_wr(p + 6 + i, i / 4, i % 4, 0);
        clear_req = 1'b1;
        run_toggle = 1'b1;
        next();
        clear_req = 1'b0;
        run_toggle = 1'b0;
        wait_until(p + 5);
        clear_req = 1'b1;
        next();
        clear_req = 1'b0;
        wait_until(p + 10);
        check("restart_busy", 32'(busy), 1);
        check("restart_running", 32'(running), 0);
        wait_until(p + 17);
        check("restart_busy_last", 32'(busy), 1);
        next();
        check("restart_busy_done", 32'(busy), 0);
        check("restart_resume_pause", 32'(running), 0);
        wait_until(p + 20);
        push_tick(p + 21);
        step_req = 1'b1;
        next();
        step_req = 1'b0;

        // Reset in the middle of a sweep
        wait_until(p + 30);
        s = cyc;
        for (int i = 0; i < 7; i++) push_wr(s + 1 + i, i / 4, i % 4, 0);
        clear_req = 1'b1;
        next();
        clear_req = 1'b0;
        wait_until(s + 7);
        rst = 1'b1;
        next();
        check("mid_rst_tick", 32'(envo_tick), 0);
        check("mid_rst_wr_en", 32'(wr_en), 0);
        check("mid_rst_wr_row", 32'(wr_row), 0);
        check("mid_rst_wr_col", 32'(wr_col), 0);
        check("mid_rst_wr_data", 32'(wr_data), 0);
        check("mid_rst_running", 32'(running), 0);
        check("mid_rst_busy", 32'(busy), 0);
        rst = 1'b0;
        wait_until(s + 30);
        check("post_rst_running", 32'(running), 0);
        push_tick(s + 31);
        step_req = 1'b1;
        next();
        step_req = 1'b0;
        wait_until(s + 40);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/envolve_scheduler.md
# envolve_scheduler

Sequencing controller for the cell-map evolution datapath. Owns run/pause/single-step, generates the one-cycle generation tick (`envo_tick`, driving the evolve logic's `clk_envo`) at a speed-selectable period, and performs a full-map clear sweep. Arbitrates the single cell-map write port between editor writes and the clear sweep. Sits between the command decoder and `envolve_logic`, in place of the ad-hoc write/tick wiring.

## Interface

Parameters:

- `MAP_WIDTH`, 8: columns in the map.
- `MAP_HEIGHT`, 8: rows in the map.
- `BASE_PERIOD`, 25_000_000: tick period in clk cycles at speed 0. Must be ≥ 256.

Ports:

- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `run_toggle`  in  1  one-cycle pulse; flips paused ↔ running.
- `step_req`  in  1  one-cycle pulse; one generation while paused.
- `clear_req`  in  1  one-cycle pulse; zero the whole map.
- `speed`  in  3  period = `BASE_PERIOD >> speed`.
- `edit_we`  in  1  editor write request.
- `edit_row`, `edit_col`  in  `ADDR_WIDTH`  editor cell address.
- `edit_data`  in  1  editor cell value.
- `envo_tick`  out  1  one-cycle generation pulse.
- `wr_en`  out  1  map write enable.
- `wr_row`, `wr_col`  out  `ADDR_WIDTH`  map write address.
- `wr_data`  out  1  map write data.
- `running`  out  1  high in RUN.
- `busy`  out  1  high during the clear sweep; editor writes are dropped.

## Operation

- FSM states:
  - PAUSE: the reset state.
  - RUN
  - CLEAR: also records `resume`, the state it was entered from.
- Transitions:
  - PAUSE --`run_toggle`--> RUN
  - RUN --`run_toggle`--> PAUSE
  - any state --`clear_req`--> CLEAR
  - CLEAR --sweep done--> `resume`
- Priority in a single cycle: `clear_req` > `run_toggle` > `step_req`.
- Step:
  - In PAUSE, `step_req` raises `envo_tick` for exactly one cycle.
  - `step_req` is ignored in RUN and CLEAR.
- Period counter (RUN only):
  - The counter is cleared when RUN is entered.
  - It increments each cycle. When `cnt >= (BASE_PERIOD >> speed) - 1`, issue a tick and reset `cnt` to 0.
  - The compare uses the current `speed`. If a speed change leaves `cnt` above the new limit, the tick fires on the next cycle.
  - The counter width is `$clog2(BASE_PERIOD)`. The counter holds its value in PAUSE and CLEAR.
- Clear sweep:
  - Writes 0 to `(row, col)`, walking row-major: col 0..MAP_WIDTH-1 inner, row 0..MAP_HEIGHT-1 outer.
  - One write per cycle, MAP_WIDTH×MAP_HEIGHT writes total.
  - A `clear_req` during CLEAR restarts the sweep at (0,0) and keeps the original `resume`.
- Editor writes:
  - Accepted in PAUSE and RUN and forwarded to the `wr_*` outputs.
  - Dropped (not queued) in CLEAR.
- Tick/write conflict: a tick never coincides with `wr_en`.
  - If a tick is due in the same cycle as an editor write, set a `pending` flag. Issue the tick on the first following cycle with no write.
  - `pending` survives only while in RUN or PAUSE. It is cleared on CLEAR entry, on `run_toggle`, and on reset.
- Reset mid-operation: any state → PAUSE. The sweep is aborted and the counter and `pending` are zeroed. Cells already cleared stay cleared.

## Timing

- All outputs are registered.
- Reset values:
  - `envo_tick` = 0, `wr_en` = 0, `wr_row` = 0, `wr_col` = 0, `wr_data` = 0.
  - `running` = 0, `busy` = 0.
- Latencies from the input cycle T:
  - Editor write at T → `wr_*` at T+1.
  - `step_req` at T → `envo_tick` at T+1.
  - `clear_req` at T → `busy` = 1 and the first write (0,0) at T+1.
  - Last write at T+W·H → `busy` = 0 at T+W·H+1.
- RUN tick spacing is exactly `BASE_PERIOD >> speed` cycles, absent conflicts. The first tick comes `BASE_PERIOD >> speed` cycles after `running` rises.
- `running` reflects the state register. During CLEAR it holds the `resume` value.

## Structure

- `ADDR_WIDTH`, the command/state encodings, and `envolve_scheduler` state constants go in the shared `defines.v`.
- One natural sub-module, `clear_sweeper`:
  - row/col counters, `start`, `done`, `wr_row`/`wr_col` outputs;
  - reusable later for random fill.
- Tick counter and FSM stay in the top.

## Test plan

Use MAP_WIDTH=4, MAP_HEIGHT=3, BASE_PERIOD=256.

1. Reset, then `run_toggle`: `running` rises at T+1. Ticks at T+257, T+513.
   - Set `speed`=3: the spacing becomes 32 cycles.
   - Set `speed`=0 with `cnt`=40: the spacing returns to 256.
2. PAUSE, `step_req` at cycle 10: single `envo_tick` at cycle 11. `step_req` while running produces no extra tick.
3. `clear_req` in RUN: `busy` for 12 cycles, writes (0,0)…(2,3) all with data 0, then RUN resumes.
   - `edit_we` mid-sweep produces no `wr_en` beyond the sweep writes.
4. Editor write coinciding with a due tick:
   - `wr_en` at T+1 with `edit_row`/`edit_col`/`edit_data` echoed.
   - Tick at T+2; the next tick spacing is measured from the original due cycle.
5. `clear_req` and `run_toggle` in the same PAUSE cycle: CLEAR entered, resumes to PAUSE. Second `clear_req` at sweep write 5 restarts at (0,0), total 5+12 writes.
6. `rst` asserted at sweep write 7: next cycle all outputs 0, state PAUSE. No further writes.
